// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: PC register, variable-latency imem handshake and IF/ID register.
// Define FETCH_STATS_EN to add the fetchCount / bubbleCount statistics ports.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        imemAck,
  output logic [31:0] ifidInstruction,
  output logic [31:0] ifidPcPlus4,
  output logic        ifidValid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] bubbleCount
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] req_addr_r, req_addr_s;
  logic [31:0] hold_buf_r, hold_buf_s;
  logic        req_r;
  logic [31:0] ifid_instr_r, ifid_pc4_r;
  logic        ifid_valid_r;
  logic        ifid_we_s, valid_s;
  logic [31:0] instr_s, pc4_s;
  logic        ack_s, redirect_s;
  logic [31:0] target_s, seq_s;

  // Next-PC selection inputs; an ack only counts while a request is actually out.
  always_comb begin
    ack_s      = imemAck & req_r;
    redirect_s = (pcSrc == 2'd1) || (pcSrc == 2'd2);
    target_s   = ((pcSrc == 2'd2) ? jumpTarget : branchTarget) & 32'hFFFF_FFFC;
    seq_s      = pc_r + 32'd4;
  end

  // Fetch FSM next-state and IF/ID write decision.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    req_addr_s = req_addr_r;
    hold_buf_s = hold_buf_r;
    ifid_we_s  = 1'b0;
    instr_s    = 32'd0;
    pc4_s      = 32'd0;
    valid_s    = 1'b0;
    case (state_r)
      FETCH: begin
        if (redirect_s) begin
          // Any word landing this cycle belongs to the wrong path.
          pc_s      = target_s;
          ifid_we_s = 1'b1;
          if (req_r && !ack_s) begin
            state_s = DROP;
          end else begin
            req_addr_s = target_s;
          end
        end else if (ack_s) begin
          if (stall) begin
            hold_buf_s = imemData;
            state_s    = HOLD;
          end else begin
            ifid_we_s  = 1'b1;
            instr_s    = imemData;
            pc4_s      = req_addr_r + 32'd4;
            valid_s    = 1'b1;
            pc_s       = seq_s;
            req_addr_s = seq_s;
          end
        end else begin
          ifid_we_s = ~stall;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          pc_s       = target_s;
          req_addr_s = target_s;
          hold_buf_s = 32'd0;
          ifid_we_s  = 1'b1;
          state_s    = FETCH;
        end else if (!stall) begin
          ifid_we_s  = 1'b1;
          instr_s    = hold_buf_r;
          pc4_s      = req_addr_r + 32'd4;
          valid_s    = 1'b1;
          pc_s       = seq_s;
          req_addr_s = seq_s;
          state_s    = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        if (redirect_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        ifid_we_s = redirect_s | ~stall;
        if (ack_s) begin
          state_s    = FETCH;
          req_addr_s = redirect_s ? target_s : pc_r;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
    if (flush) begin
      ifid_we_s = 1'b1;
      instr_s   = 32'd0;
      pc4_s     = 32'd0;
      valid_s   = 1'b0;
    end else begin
      ifid_we_s = ifid_we_s;
    end
  end

  // State, PC, request address, hold buffer and request strobe registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      hold_buf_r <= 32'd0;
      req_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      req_addr_r <= req_addr_s;
      hold_buf_r <= hold_buf_s;
      req_r      <= (state_s != HOLD);
    end
  end

  // IF/ID pipeline register; untouched on stall holds.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ifid_instr_r <= 32'd0;
      ifid_pc4_r   <= 32'd0;
      ifid_valid_r <= 1'b0;
    end else if (ifid_we_s) begin
      ifid_instr_r <= instr_s;
      ifid_pc4_r   <= pc4_s;
      ifid_valid_r <= valid_s;
    end
  end

  assign imemReq         = req_r;
  assign imemAddr        = req_addr_r;
  assign ifidInstruction = ifid_instr_r;
  assign ifidPcPlus4     = ifid_pc4_r;
  assign ifidValid       = ifid_valid_r;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_r, bubble_cnt_r;

  // Statistics: real loads versus bubble writes into IF/ID.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      fetch_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else if (ifid_we_s) begin
      if (valid_s) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end
    end
  end

  assign fetchCount  = fetch_cnt_r;
  assign bubbleCount = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed, table-driven bench for mips_fetch_stage with a word-indexed memory pattern.
module tb_mips_fetch_stage;

  logic        clock = 1'b0;
  logic        nReset;
  logic        stall, flush;
  logic [1:0]  pcSrc;
  logic [31:0] branchTarget, jumpTarget;
  logic        imemReq;
  logic [31:0] imemAddr, imemData;
  logic        imemAck;
  logic [31:0] ifidInstruction, ifidPcPlus4;
  logic        ifidValid;
`ifdef FETCH_STATS_EN
  logic [31:0] fetchCount, bubbleCount;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mips_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .nReset(nReset), .stall(stall), .flush(flush), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .jumpTarget(jumpTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemData(imemData), .imemAck(imemAck),
    .ifidInstruction(ifidInstruction), .ifidPcPlus4(ifidPcPlus4), .ifidValid(ifidValid)
`ifdef FETCH_STATS_EN
    , .fetchCount(fetchCount), .bubbleCount(bubbleCount)
`endif
  );

  always #5 clock = ~clock;

  // Memory contents: word n holds 0x20010001 + n.
  assign imemData = 32'h2001_0001 + {2'b00, imemAddr[31:2]};

  typedef struct {
    logic        st;
    logic        fl;
    logic [1:0]  src;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic fl, input logic [1:0] src,
                     input logic [31:0] bt, input logic [31:0] jt, input logic ack,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
    vec_t v;
    v.st = st; v.fl = fl; v.src = src; v.bt = bt; v.jt = jt; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
    check32({tag, " imemReq"}, {31'd0, imemReq}, {31'd0, e_req});
    check32({tag, " imemAddr"}, imemAddr, e_addr);
    check32({tag, " ifidInstruction"}, ifidInstruction, e_instr);
    check32({tag, " ifidPcPlus4"}, ifidPcPlus4, e_pc4);
    check32({tag, " ifidValid"}, {31'd0, ifidValid}, {31'd0, e_valid});
  endtask

  initial begin
    nReset = 1'b0; stall = 1'b0; flush = 1'b0; pcSrc = 2'd0;
    branchTarget = 32'd0; jumpTarget = 32'd0; imemAck = 1'b0;

    //   st    fl    src    bt             jt            ack   req   addr           instr          pc4            v
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b0, 1'b1, 32'h0,         32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h4,         32'h2001_0001, 32'h4,         1'b1);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h8,         32'h2001_0002, 32'h8,         1'b1);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'hC,         32'h2001_0003, 32'hC,         1'b1);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b0, 1'b1, 32'hC,         32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b0, 1'b1, 32'hC,         32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h10,        32'h2001_0004, 32'h10,        1'b1);
    add(1'b1, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b0, 32'h10,        32'h2001_0004, 32'h10,        1'b1);
    add(1'b1, 1'b0, 2'd0, 32'h0,         32'h0,        1'b0, 1'b0, 32'h10,        32'h2001_0004, 32'h10,        1'b1);
    add(1'b1, 1'b0, 2'd0, 32'h0,         32'h0,        1'b0, 1'b0, 32'h10,        32'h2001_0004, 32'h10,        1'b1);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b0, 1'b1, 32'h14,        32'h2001_0005, 32'h14,        1'b1);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h18,        32'h2001_0006, 32'h18,        1'b1);
    add(1'b0, 1'b0, 2'd1, 32'h40,        32'h80,       1'b0, 1'b1, 32'h18,        32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b0, 1'b1, 32'h18,        32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h40,        32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h44,        32'h2001_0011, 32'h44,        1'b1);
    add(1'b0, 1'b0, 2'd2, 32'h200,       32'h103,      1'b1, 1'b1, 32'h100,       32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h104,       32'h2001_0041, 32'h104,       1'b1);
    add(1'b0, 1'b0, 2'd3, 32'h40,        32'h80,       1'b1, 1'b1, 32'h108,       32'h2001_0042, 32'h108,       1'b1);
    add(1'b1, 1'b1, 2'd0, 32'h0,         32'h0,        1'b0, 1'b1, 32'h108,       32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h10C,       32'h2001_0043, 32'h10C,       1'b1);
    add(1'b0, 1'b1, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h110,       32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFC, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h0,         32'h6001_0000, 32'h0,         1'b1);
    add(1'b0, 1'b0, 2'd0, 32'h0,         32'h0,        1'b1, 1'b1, 32'h4,         32'h2001_0001, 32'h4,         1'b1);

    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    nReset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      stall = vecs[i].st; flush = vecs[i].fl; pcSrc = vecs[i].src;
      branchTarget = vecs[i].bt; jumpTarget = vecs[i].jt; imemAck = vecs[i].ack;
      @(posedge clock);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_valid);
    end

    // Asynchronous reset in the middle of an outstanding request.
    @(negedge clock);
    stall = 1'b0; flush = 1'b0; pcSrc = 2'd0; imemAck = 1'b0;
    @(posedge clock);
    #2;
    nReset = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_STATS_EN
    check32("fetchCount after reset", fetchCount, 32'd0);
    check32("bubbleCount after reset", bubbleCount, 32'd0);
`endif
    @(negedge clock);
    nReset = 1'b1;
    imemAck = 1'b1;
    @(posedge clock);
    #1;
    check_all("post_reset_first", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clock);
    #1;
    check_all("post_reset_fetch", 1'b1, 32'h4, 32'h2001_0001, 32'h4, 1'b1);
`ifdef FETCH_STATS_EN
    check32("fetchCount after one load", fetchCount, 32'd1);
    check32("bubbleCount after one bubble", bubbleCount, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
